prog_loader: RTL and testbench

Instruction-memory writer for the 16-bit processor core. Receives a length-prefixed, XOR-checksummed byte stream, assembles big-endian 16-bit instructions into the 8-entry instruction store, and serves the core's fetch port. Holds the core in reset until a complete, checksum-valid program is resident. Replaces the core's hard-coded instruction initialisation.

---
 rtl/proc_isa_pkg.sv | 43 ++++
 rtl/instr_mem.sv | 31 +++
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_isa_pkg.sv
// Shared ISA constants and loader types for the 16-bit core.
// Holds the opcode map, field positions and loader state encoding.
package proc_isa_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 3;
  localparam int IW_DEF    = 16;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_ST  = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_DONE,
    ST_FAIL
  } ld_state_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR,
      OP_LDI, OP_ST: ok = 1'b1;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction store: one write port, clear-all, async read.
// Clear takes priority so a restarting load never sees stale words.
module instr_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  // clear wipes every entry; otherwise single word write
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader and fetch port for the 16-bit core.
// Keeps the core in reset until a checksum-valid program is resident.
module prog_loader
  import proc_isa_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [IW-1:0] fetch_instr,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic          err_illegal,
  output logic [3:0]    illegal_cnt,
  output logic [7:0]    checksum
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  ld_state_t state;
  ld_state_t state_nxt;

  logic          xfer;
  logic          load_go;
  logic          len_bad;
  logic [AW:0]   len_q;
  logic [AW:0]   idx_q;
  logic [AW:0]   idx_nx;
  logic [7:0]    hi_q;
  logic [7:0]    cks_q;
  logic [3:0]    cnt_q;
  logic          err_q;
  logic          mem_we;
  logic          mem_clr;
  logic [IW-1:0] word;
  logic          word_ok;

  assign xfer    = rx_valid & rx_ready;
  assign len_bad = (rx_data == 8'd0) || (rx_data > DEPTH_B);
  assign idx_nx  = idx_q + ONE;
  assign word    = IW'({hi_q, rx_data});
  assign word_ok = op_legal(word[OP_HI:OP_LO]);
  assign mem_we  = xfer && (state == ST_LO);
  assign mem_clr = reset | load_go;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE,
      ST_DONE,
      ST_FAIL: if (start) state_nxt = ST_LEN;
      ST_LEN: if (xfer)
        state_nxt = len_bad ? ST_FAIL : ST_HI;
      ST_HI: if (xfer) state_nxt = ST_LO;
      ST_LO: if (xfer)
        state_nxt = (idx_nx == len_q) ? ST_CHK : ST_HI;
      ST_CHK: if (xfer)
        state_nxt = (rx_data == cks_q) ? ST_DONE : ST_FAIL;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // status outputs and load-start strobe
  always_comb begin
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    core_reset = 1'b1;
    load_go    = 1'b0;
    unique case (1'b1)
      (state == ST_LEN),
      (state == ST_HI),
      (state == ST_LO),
      (state == ST_CHK): begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      (state == ST_DONE): begin
        done       = 1'b1;
        core_reset = 1'b0;
        load_go    = start;
      end
      (state == ST_FAIL): begin
        fail    = 1'b1;
        load_go = start;
      end
      default: load_go = start;
    endcase
  end

  // length, word index, checksum and opcode bookkeeping
  always_ff @(posedge clk) begin
    if (reset || load_go) begin
      len_q <= '0;
      idx_q <= '0;
      hi_q  <= '0;
      cks_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (xfer) begin
      if (state != ST_CHK)
        cks_q <= cks_q ^ rx_data;
      unique case (1'b1)
        (state == ST_LEN):
          len_q <= rx_data[AW:0];
        (state == ST_HI):
          hi_q <= rx_data;
        (state == ST_LO): begin
          idx_q <= idx_nx;
          if (!word_ok) begin
            err_q <= 1'b1;
            if (cnt_q != 4'hF)
              cnt_q <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign checksum    = cks_q;
  assign illegal_cnt = cnt_q;
  assign err_illegal = err_q;

  instr_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .clear (mem_clr),
    .we    (mem_we),
    .waddr (idx_q[AW-1:0]),
    .wdata (word),
    .raddr (fetch_addr),
    .rdata (fetch_instr)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader.
// Loads are modelled from the byte stream; a monitor checks each end of load.
module tb_prog_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];

  typedef struct packed {
    logic             done;
    logic             fail;
    logic             err;
    logic [3:0]       cnt;
    logic [7:0]       cks;
    logic [7:0][15:0] mem;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [2:0]  fetch_addr;
  logic [15:0] fetch_instr;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        fail;
  logic        err_illegal;
  logic [3:0]  illegal_cnt;
  logic [7:0]  checksum;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  always #10 clk = ~clk;

  prog_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt),
    .checksum    (checksum)
  );

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'hA};
  endfunction

  // expected outcome of one load, straight from the stream rules
  function automatic exp_t model(input bq_t b);
    exp_t e;
    int n;
    logic [7:0] x;
    logic [7:0] hi;
    logic [7:0] lo;
    e = '0;
    n = int'(b[0]);
    x = b[0];
    if (n == 0 || n > 8) begin
      e.fail = 1'b1;
      e.cks  = x;
      return e;
    end
    for (int w = 0; w < n; w++) begin
      hi = b[1 + 2*w];
      lo = b[2 + 2*w];
      x  = x ^ hi ^ lo;
      e.mem[w] = {hi, lo};
      if (!legal(hi[7:4])) begin
        e.err = 1'b1;
        if (e.cnt != 4'hF) e.cnt = e.cnt + 4'd1;
      end
    end
    e.cks = x;
    if (b[2*n + 1] == x) e.done = 1'b1;
    else                 e.fail = 1'b1;
    return e;
  endfunction

  function automatic bq_t mk(input wq_t w, input bit bad);
    bq_t b;
    logic [7:0] x;
    x = 8'(w.size());
    b.push_back(x);
    foreach (w[i]) begin
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
      x = x ^ w[i][15:8] ^ w[i][7:0];
    end
    b.push_back(bad ? (x ^ 8'h5A) : x);
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] v, input bit gaps);
    int t;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = v;
    t = 0;
    while (!rx_ready && t < 16) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!rx_ready) cmp("rx_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    cmp("start_ready", 32'(rx_ready), 32'd1);
    cmp("start_core_reset", 32'(core_reset), 32'd1);
    cmp("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_load(input bq_t b, input bit gaps);
    sb.push_back(model(b));
    pulse_start();
    foreach (b[i]) send_byte(b[i], gaps);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // monitor: every busy->idle transition retires one expectation
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    fetch_addr = '0;
    forever begin
      @(negedge clk);
      if (prev && !busy) begin
        if (sb.size() == 0) begin
          cmp("unexpected_end", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          cmp("done", 32'(done), 32'(e.done));
          cmp("fail", 32'(fail), 32'(e.fail));
          cmp("err_illegal", 32'(err_illegal), 32'(e.err));
          cmp("illegal_cnt", 32'(illegal_cnt), 32'(e.cnt));
          cmp("checksum", 32'(checksum), 32'(e.cks));
          cmp("core_reset", 32'(core_reset), 32'(!e.done));
          cmp("rx_ready_after", 32'(rx_ready), 32'd0);
          for (int i = 0; i < 8; i++) begin
            fetch_addr = 3'(i);
            #1;
            cmp($sformatf("mem[%0d]", i), 32'(fetch_instr),
                32'(e.mem[i]));
          end
          fetch_addr = '0;
        end
      end
      prev = busy;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t w;
    bq_t b;
    int  n;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    cmp("rst_rx_ready", 32'(rx_ready), 32'd0);
    cmp("rst_core_reset", 32'(core_reset), 32'd1);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_fail", 32'(fail), 32'd0);
    cmp("rst_err", 32'(err_illegal), 32'd0);
    cmp("rst_cnt", 32'(illegal_cnt), 32'd0);
    cmp("rst_cks", 32'(checksum), 32'd0);

    w = {};
    w.push_back(16'h8007);
    do_load(mk(w, 1'b0), 1'b0);
    do_load(mk(w, 1'b1), 1'b0);

    b = {};
    b.push_back(8'h00);
    do_load(b, 1'b0);
    b = {};
    b.push_back(8'h09);
    do_load(b, 1'b0);

    w.push_back(16'hF000);
    do_load(mk(w, 1'b0), 1'b0);

    w = {};
    w.push_back(16'h8007);
    w.push_back(16'h8202);
    w.push_back(16'h8408);
    w.push_back(16'h8601);
    w.push_back(16'h0E09);
    w.push_back(16'h0C9C);
    w.push_back(16'hAEFF);
    w.push_back(16'hACFE);
    do_load(mk(w, 1'b0), 1'b1);

    w = {};
    w.push_back(16'h1234);
    do_load(mk(w, 1'b0), 1'b1);

    sb.push_back('0);
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h80, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int k = 0; k < 12; k++) begin
      w = {};
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      do_load(mk(w, $urandom_range(0, 3) == 0), 1'b1);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
